// File: rtl/alarm_ctrl_if.sv
// Alarm clock controller bus: switch/button/tick inputs and display/status outputs.
interface alarm_ctrl_if;
    logic       tick_1hz;
    logic       alarm_en;
    logic       set_time;
    logic       set_alarm;
    logic       btn_hour;
    logic       btn_min;
    logic       btn_snooze;
    logic       hourten;
    logic [3:0] hour;
    logic [2:0] minten;
    logic [3:0] min;
    logic       ring;
    logic [2:0] state;

    modport master (
        output tick_1hz, alarm_en, set_time, set_alarm, btn_hour, btn_min, btn_snooze,
        input  hourten, hour, minten, min, ring, state
    );

    modport slave (
        input  tick_1hz, alarm_en, set_time, set_alarm, btn_hour, btn_min, btn_snooze,
        output hourten, hour, minten, min, ring, state
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock sequencing: 12-hour BCD timekeeping, alarm register, mode FSM
// (run / set time / set alarm / ringing / snooze) and display source select.
//
//  state     | meaning
//  ----------+-------------------------------------------------
//  RUN       | clock runs, alarm compared on minute rollover
//  SET_TIME  | time frozen (sec held 0), buttons edit the time
//  SET_ALARM | clock runs, buttons edit the alarm, alarm shown
//  RINGING   | ring asserted, timeout counts minutes
//  SNOOZE    | ring off, counts down minutes before re-ringing
module alarm_ctrl #(
    parameter int SEC_PER_MIN      = 60,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input  logic         CLK100MHZ,
    input  logic         rst,
    alarm_ctrl_if.slave  bus
);
    localparam int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
    localparam int SNZ_W = $clog2(SNOOZE_MIN + 1);
    localparam int TO_W  = $clog2(RING_TIMEOUT_MIN + 1);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_TIME  = 3'd1,
        SET_ALARM = 3'd2,
        RINGING   = 3'd3,
        SNOOZE    = 3'd4
    } state_t;

    typedef struct packed {
        logic       ht;
        logic [3:0] h;
        logic [2:0] mt;
        logic [3:0] m;
    } hm_t;

    localparam hm_t TIME_RST  = '{ht: 1'b1, h: 4'd2, mt: 3'd0, m: 4'd0};
    localparam hm_t ALARM_RST = '{ht: 1'b0, h: 4'd6, mt: 3'd0, m: 4'd0};

    // 12-hour BCD hour increment: 09 -> 10, 12 -> 01.
    function automatic hm_t inc_hour(hm_t t);
        hm_t r = t;
        if (t.ht && t.h == 4'd2) begin
            r.ht = 1'b0;
            r.h  = 4'd1;
        end else if (t.h == 4'd9) begin
            r.ht = 1'b1;
            r.h  = 4'd0;
        end else begin
            r.h = t.h + 4'd1;
        end
        return r;
    endfunction

    // BCD minute increment; carry selects whether 59 -> 00 bumps the hour.
    function automatic hm_t inc_min(hm_t t, logic carry);
        hm_t r = t;
        if (t.m != 4'd9) begin
            r.m = t.m + 4'd1;
        end else begin
            r.m = 4'd0;
            if (t.mt != 3'd5) begin
                r.mt = t.mt + 3'd1;
            end else begin
                r.mt = 3'd0;
                if (carry) r = inc_hour(r);
            end
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    hm_t              time_q, time_d, alarm_q, alarm_d;
    logic [SNZ_W-1:0] snz_q, snz_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             prev_hour, prev_min, prev_snooze;
    logic             edge_hour, edge_min, edge_snooze;
    logic             rollover;
    hm_t              disp_d, disp_q;
    logic             ring_d, ring_q;

    assign edge_hour   = bus.btn_hour   & ~prev_hour;
    assign edge_min    = bus.btn_min    & ~prev_min;
    assign edge_snooze = bus.btn_snooze & ~prev_snooze;
    assign rollover    = bus.tick_1hz && (state_q != SET_TIME) &&
                         (sec_q == SEC_W'(SEC_PER_MIN - 1));

    // State register.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next time/alarm values: seconds counting, minute carry, and button edits in the set modes.
    always_comb begin
        sec_d   = sec_q;
        time_d  = time_q;
        alarm_d = alarm_q;
        if (state_q == SET_TIME) begin
            sec_d = '0;
            if (edge_hour) time_d = inc_hour(time_d);
            if (edge_min)  time_d = inc_min(time_d, 1'b0);
        end else begin
            if (rollover) begin
                sec_d  = '0;
                time_d = inc_min(time_q, 1'b1);
            end else if (bus.tick_1hz) begin
                sec_d = sec_q + SEC_W'(1);
            end
            if (state_q == SET_ALARM) begin
                if (edge_hour) alarm_d = inc_hour(alarm_d);
                if (edge_min)  alarm_d = inc_min(alarm_d, 1'b0);
            end
        end
    end

    // Next-state logic with snooze and ring-timeout minute counters; switches override everything.
    always_comb begin
        state_d = state_q;
        snz_d   = snz_q;
        to_d    = to_q;
        if (bus.set_time) begin
            state_d = SET_TIME;
        end else if (bus.set_alarm) begin
            state_d = SET_ALARM;
        end else begin
            case (state_q)
                SET_TIME, SET_ALARM: state_d = RUN;
                RUN: begin
                    if (bus.alarm_en && rollover && time_d == alarm_q) begin
                        state_d = RINGING;
                        to_d    = '0;
                    end
                end
                RINGING: begin
                    if (!bus.alarm_en) begin
                        state_d = RUN;
                    end else if (edge_snooze) begin
                        state_d = SNOOZE;
                        snz_d   = SNZ_W'(SNOOZE_MIN);
                    end else if (rollover) begin
                        to_d = to_q + TO_W'(1);
                        if (to_d == TO_W'(RING_TIMEOUT_MIN)) state_d = RUN;
                    end
                end
                SNOOZE: begin
                    if (!bus.alarm_en) begin
                        state_d = RUN;
                    end else if (rollover) begin
                        snz_d = snz_q - SNZ_W'(1);
                        if (snz_d == '0) begin
                            state_d = RINGING;
                            to_d    = '0;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track the cycle of change.
    always_comb begin
        disp_d = (state_d == SET_ALARM) ? alarm_d : time_d;
        ring_d = (state_d == RINGING);
    end

    // Datapath registers; button history resets high so a button held through reset gives no edge.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            sec_q       <= '0;
            time_q      <= TIME_RST;
            alarm_q     <= ALARM_RST;
            snz_q       <= '0;
            to_q        <= '0;
            prev_hour   <= 1'b1;
            prev_min    <= 1'b1;
            prev_snooze <= 1'b1;
        end else begin
            sec_q       <= sec_d;
            time_q      <= time_d;
            alarm_q     <= alarm_d;
            snz_q       <= snz_d;
            to_q        <= to_d;
            prev_hour   <= bus.btn_hour;
            prev_min    <= bus.btn_min;
            prev_snooze <= bus.btn_snooze;
        end
    end

    // Registered display and ring outputs.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            disp_q <= TIME_RST;
            ring_q <= 1'b0;
        end else begin
            disp_q <= disp_d;
            ring_q <= ring_d;
        end
    end

    assign bus.hourten = disp_q.ht;
    assign bus.hour    = disp_q.h;
    assign bus.minten  = disp_q.mt;
    assign bus.min     = disp_q.m;
    assign bus.ring    = ring_q;
    assign bus.state   = state_q;
endmodule
